// File: rtl/instr_decoder_if.sv
// Bus bundle between the instruction producer, the decoder and the consumer.
//
// Handshake: a word moves across a side only on a cycle where that side's
// valid and ready are both high at the rising clock edge. A source asserting
// valid keeps its payload stable until the transfer happens. A sink may raise
// or lower ready at any time. The decoder's in_ready comes straight from a
// register, so it never depends combinationally on in_valid.
interface instr_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [1:0]  out_format;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic [2:0]  out_alu_op;
    logic [2:0]  out_cond;
    logic        out_is_branch;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_is_jump;
    logic        out_is_stack;

    // Decoder side.
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_format, out_rd, out_rs1,
               out_rs2, out_imm, out_use_imm, out_alu_op, out_cond,
               out_is_branch, out_is_load, out_is_store, out_is_jump,
               out_is_stack
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_format, out_rd, out_rs1,
               out_rs2, out_imm, out_use_imm, out_alu_op, out_cond,
               out_is_branch, out_is_load, out_is_store, out_is_jump,
               out_is_stack
    );
endinterface

// File: rtl/instr_decoder.sv
// Instruction decoder: splits a 32-bit word into fields, classifies it, and
// presents the decoded bundle one cycle later through a 2-entry skid buffer
// (output register plus one skid register) so in_ready can be registered.
module instr_decoder (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    instr_decoder_if.slave        bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [4:0] {
        op_add  = 5'd0,  op_add2 = 5'd1,  op_sub  = 5'd2,  op_sub2 = 5'd3,
        op_mul  = 5'd4,  op_mul2 = 5'd5,  op_div  = 5'd6,  op_div2 = 5'd7,
        op_and  = 5'd8,  op_and2 = 5'd9,  op_or   = 5'd10, op_or2  = 5'd11,
        op_ls   = 5'd12, op_ls2  = 5'd13, op_rs   = 5'd14, op_rs2  = 5'd15,
        op_beq  = 5'd16, op_bne  = 5'd17, op_blt  = 5'd18, op_bgt  = 5'd19,
        op_ble  = 5'd20, op_bge  = 5'd21, op_lw   = 5'd22, op_lb   = 5'd23,
        op_sw   = 5'd24, op_sb   = 5'd25, op_j    = 5'd26, op_jr   = 5'd27,
        op_call = 5'd28, op_ret  = 5'd29, op_push = 5'd30, op_pop  = 5'd31
    } opcode_t;

    typedef enum logic [1:0] {
        fmt_t = 2'd0,
        fmt_d = 2'd1,
        fmt_i = 2'd2
    } format_t;

    typedef enum logic [2:0] {
        alu_add = 3'd0, alu_sub = 3'd1, alu_mul = 3'd2, alu_div = 3'd3,
        alu_and = 3'd4, alu_or  = 3'd5, alu_ls  = 3'd6, alu_rs  = 3'd7
    } alu_t;

    typedef enum logic [2:0] {
        cond_eq = 3'd0, cond_ne = 3'd1, cond_lt = 3'd2,
        cond_gt = 3'd3, cond_le = 3'd4, cond_ge = 3'd5
    } cond_t;

    typedef struct packed {
        opcode_t     opcode;
        format_t     fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        alu_t        alu_op;
        cond_t       cond;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        is_jump;
        logic        is_stack;
    } bundle_t;

    // st_empty: nothing held; st_one: output register valid;
    // st_full: output register and skid register both valid.
    typedef enum logic [1:0] {
        st_empty = 2'd0,
        st_one   = 2'd1,
        st_full  = 2'd2
    } state_t;

    state_t  state, state_next;
    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q, out_valid_next;
    logic    in_ready_q, in_ready_next;
    logic    in_fire, out_fire;
    logic    load_out, load_skid, out_from_skid;

    // Combinational decode of the incoming word; the skid stores this result.
    always_comb begin
        dec           = '0;
        dec.opcode    = opcode_t'(bus.in_instr[31:27]);
        dec.rd        = bus.in_instr[26:22];
        dec.rs1       = bus.in_instr[21:17];
        dec.rs2       = bus.in_instr[16:12];
        dec.fmt       = fmt_t;
        dec.alu_op    = alu_add;
        dec.cond      = cond_eq;
        case (dec.opcode)
            op_beq, op_bne, op_blt, op_bgt, op_ble, op_bge: begin
                dec.is_branch = 1'b1;
                // Branch opcodes start at 16, so the low bits are the condition.
                dec.cond      = cond_t'(bus.in_instr[29:27]);
            end
            op_lw, op_lb: begin
                dec.fmt     = fmt_d;
                dec.is_load = 1'b1;
            end
            op_sw, op_sb: begin
                dec.is_store = 1'b1;
            end
            op_j: begin
                dec.fmt     = fmt_i;
                dec.is_jump = 1'b1;
            end
            op_jr: begin
                dec.fmt     = fmt_d;
                dec.is_jump = 1'b1;
            end
            op_call, op_ret: begin
                dec.fmt      = fmt_i;
                dec.is_jump  = 1'b1;
                dec.is_stack = 1'b1;
            end
            op_push: begin
                dec.fmt      = fmt_d;
                dec.is_stack = 1'b1;
            end
            op_pop: begin
                dec.fmt      = fmt_i;
                dec.is_stack = 1'b1;
            end
            default: begin
                // ALU group 0-15: odd opcodes are the immediate-capable D form.
                dec.fmt    = bus.in_instr[27] ? fmt_d : fmt_t;
                dec.alu_op = alu_t'(bus.in_instr[30:28]);
            end
        endcase
        case (dec.fmt)
            fmt_d: begin
                dec.imm     = {{16{bus.in_instr[16]}}, bus.in_instr[16:1]};
                dec.use_imm = bus.in_instr[0];
                dec.rs2     = 5'd0;
            end
            fmt_i: begin
                dec.imm     = {{10{bus.in_instr[21]}}, bus.in_instr[21:0]};
                dec.use_imm = 1'b1;
                dec.rs1     = 5'd0;
                dec.rs2     = 5'd0;
            end
            default: begin
                dec.imm     = {{20{bus.in_instr[11]}}, bus.in_instr[11:0]};
                dec.use_imm = 1'b0;
            end
        endcase
    end

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // Skid-buffer next state and register load controls; flush wins over everything.
    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            st_empty: begin
                if (in_fire) begin
                    load_out   = 1'b1;
                    state_next = st_one;
                end
            end
            st_one: begin
                if (out_fire) begin
                    if (in_fire) load_out = 1'b1;
                    else         state_next = st_empty;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = st_full;
                end
            end
            st_full: begin
                if (out_fire) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_next    = st_one;
                end
            end
            default: state_next = st_empty;
        endcase
        if (flush) begin
            state_next = st_empty;
            load_out   = 1'b0;
            load_skid  = 1'b0;
        end
        out_valid_next = (state_next != st_empty);
        in_ready_next  = (state_next != st_full);
    end

    // State, valid and ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= st_empty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_next;
            out_valid_q <= out_valid_next;
            in_ready_q  <= in_ready_next;
        end
    end

    // Output and skid data registers; held unchanged unless loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) out_q <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_opcode    = out_q.opcode;
    assign bus.out_format    = out_q.fmt;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_use_imm   = out_q.use_imm;
    assign bus.out_alu_op    = out_q.alu_op;
    assign bus.out_cond      = out_q.cond;
    assign bus.out_is_branch = out_q.is_branch;
    assign bus.out_is_load   = out_q.is_load;
    assign bus.out_is_store  = out_q.is_store;
    assign bus.out_is_jump   = out_q.is_jump;
    assign bus.out_is_stack  = out_q.is_stack;
    assign dbg_state         = state;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed scenarios plus a randomized stream
// checked against a queue-based model of the decoder's behaviour.
module tb_instr_decoder;

    localparam int W = 66;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] dbg_state;

    instr_decoder_if bus ();

    instr_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and initial input levels.
    always #5 clk = ~clk;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    // Reference decode written from the instruction-set rules.
    // Packing: {opcode, format, rd, rs1, rs2, imm, use_imm, alu_op, cond,
    //           branch, load, store, jump, stack}
    function automatic logic [W-1:0] ref_decode(input logic [31:0] w);
        int op, fmt, imm, alu, cond;
        logic [4:0] rd, rs1, rs2;
        logic ui, br, ld, st, jp, sk;
        op  = int'(w[31:27]);
        rd  = w[26:22];
        rs1 = w[21:17];
        rs2 = w[16:12];
        br  = (op >= 16 && op <= 21);
        ld  = (op == 22 || op == 23);
        st  = (op == 24 || op == 25);
        jp  = (op >= 26 && op <= 29);
        sk  = (op >= 28);
        if ((op < 16 && op % 2 == 0) || br || st) fmt = 0;
        else if ((op < 16 && op % 2 == 1) || ld || op == 27 || op == 30) fmt = 1;
        else fmt = 2;
        alu  = (op < 16) ? op / 2 : 0;
        cond = br ? op - 16 : 0;
        if (fmt == 0) begin
            imm = int'(w[11:0]);
            if (imm >= 2048) imm -= 4096;
            ui = 1'b0;
        end else if (fmt == 1) begin
            imm = int'(w[16:1]);
            if (imm >= 32768) imm -= 65536;
            ui  = w[0];
            rs2 = 5'd0;
        end else begin
            imm = int'(w[21:0]);
            if (imm >= 2097152) imm -= 4194304;
            ui  = 1'b1;
            rs1 = 5'd0;
            rs2 = 5'd0;
        end
        return {op[4:0], fmt[1:0], rd, rs1, rs2, imm, ui, alu[2:0], cond[2:0],
                br, ld, st, jp, sk};
    endfunction

    function automatic logic [W-1:0] dut_bundle();
        return {bus.out_opcode, bus.out_format, bus.out_rd, bus.out_rs1, bus.out_rs2,
                bus.out_imm, bus.out_use_imm, bus.out_alu_op, bus.out_cond,
                bus.out_is_branch, bus.out_is_load, bus.out_is_store,
                bus.out_is_jump, bus.out_is_stack};
    endfunction

    // Driver: applies one cycle of inputs at the falling edge, advances the
    // model by the same cycle, and returns at the next falling edge.
    task automatic tick(input logic v, input logic [31:0] w, input logic r,
                        input logic f, output logic acc);
        logic ofire, ifire;
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.out_ready = r;
        flush         = f;
        ofire = r && (exp_q.size() > 0);
        ifire = v && (exp_q.size() < 2);
        acc   = 1'b0;
        if (f) begin
            exp_q.delete();
        end else begin
            if (ofire) void'(exp_q.pop_front());
            if (ifire) exp_q.push_back(ref_decode(w));
            acc = ifire;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (dut_bundle() !== '0) $display("FAIL reset_outputs: got %h expected 0", dut_bundle());
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_add2();
        logic acc;
        logic [31:0] w;
        w = {5'd1, 5'd3, 5'd4, 16'hFFFF, 1'b1};
        tick(1'b1, w, 1'b1, 1'b0, acc);
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL add2_valid: got %b expected 1", bus.out_valid);
        else n_pass++;
        n_checks++;
        if ({bus.out_format, bus.out_alu_op, bus.out_imm, bus.out_use_imm} !== {2'd1, 3'd0, 32'hFFFFFFFF, 1'b1})
            $display("FAIL add2_fields: got fmt=%0d alu=%0d imm=%h ui=%b expected fmt=1 alu=0 imm=ffffffff ui=1",
                     bus.out_format, bus.out_alu_op, bus.out_imm, bus.out_use_imm);
        else n_pass++;
        n_checks++;
        if ({bus.out_rd, bus.out_rs1, bus.out_rs2} !== {5'd3, 5'd4, 5'd0})
            $display("FAIL add2_regs: got rd=%0d rs1=%0d rs2=%0d expected 3 4 0", bus.out_rd, bus.out_rs1, bus.out_rs2);
        else n_pass++;
        drain();
    endtask

    task automatic test_bgt();
        logic acc;
        logic [31:0] w;
        w = {5'd19, 5'd0, 5'd1, 5'd2, 12'h010};
        tick(1'b1, w, 1'b1, 1'b0, acc);
        n_checks++;
        if ({bus.out_valid, bus.out_format, bus.out_cond, bus.out_is_branch, bus.out_imm} !==
            {1'b1, 2'd0, 3'd3, 1'b1, 32'h00000010})
            $display("FAIL bgt_fields: got v=%b fmt=%0d cond=%0d br=%b imm=%h expected v=1 fmt=0 cond=3 br=1 imm=00000010",
                     bus.out_valid, bus.out_format, bus.out_cond, bus.out_is_branch, bus.out_imm);
        else n_pass++;
        n_checks++;
        if ({bus.out_rs1, bus.out_rs2} !== {5'd1, 5'd2})
            $display("FAIL bgt_regs: got rs1=%0d rs2=%0d expected 1 2", bus.out_rs1, bus.out_rs2);
        else n_pass++;
        drain();
    endtask

    task automatic test_stall();
        logic acc;
        logic [31:0] words[3];
        logic [W-1:0] seen[$];
        int idx;
        for (int k = 0; k < 3; k++) words[k] = $urandom();
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, words[idx > 2 ? 2 : idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
            n_checks++;
            if (bus.out_valid !== 1'b1 || dut_bundle() !== ref_decode(words[0]))
                $display("FAIL stall_hold_%0d: got v=%b %h expected v=1 %h", c, bus.out_valid, dut_bundle(), ref_decode(words[0]));
            else n_pass++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
        else n_pass++;
        for (int c = 0; c < 10 && seen.size() < 3; c++) begin
            if (bus.out_valid === 1'b1) seen.push_back(dut_bundle());
            tick(idx < 3, words[idx > 2 ? 2 : idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        n_checks++;
        if (seen.size() != 3) $display("FAIL stall_count: got %0d expected 3", seen.size());
        else n_pass++;
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            n_checks++;
            if (seen[k] !== ref_decode(words[k]))
                $display("FAIL stall_order_%0d: got %h expected %h", k, seen[k], ref_decode(words[k]));
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic acc;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, $urandom(), 1'b1, 1'b0, acc);
            n_checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || exp_q.size() != 1 || dut_bundle() !== exp_q[0])
                $display("FAIL b2b_%0d: got rdy=%b v=%b %h expected rdy=1 v=1 %h",
                         i, bus.in_ready, bus.out_valid, dut_bundle(), exp_q.size() > 0 ? exp_q[0] : '0);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_flush();
        logic acc;
        tick(1'b1, $urandom(), 1'b0, 1'b0, acc);
        tick(1'b1, $urandom(), 1'b0, 1'b0, acc);
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10)
            $display("FAIL flush_full: got v=%b rdy=%b expected v=1 rdy=0", bus.out_valid, bus.in_ready);
        else n_pass++;
        tick(1'b1, $urandom(), 1'b1, 1'b1, acc);
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL flush_after: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'd0, 1'b1, 1'b0, acc);
            n_checks++;
            if (bus.out_valid !== 1'b0) $display("FAIL flush_leak_%0d: got v=%b expected 0", i, bus.out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) tick(1'b1, $urandom(), i[0], 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || dut_bundle() !== '0)
            $display("FAIL midrst_zero: got v=%b %h expected v=0 0", bus.out_valid, dut_bundle());
        else n_pass++;
        exp_q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL midrst_idle: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        w = {5'd28, 5'd7, 22'h3FFFF0};
        tick(1'b1, w, 1'b1, 1'b0, acc);
        n_checks++;
        if ({bus.out_valid, bus.out_format, bus.out_is_jump, bus.out_is_stack, bus.out_imm, bus.out_rd} !==
            {1'b1, 2'd2, 1'b1, 1'b1, 32'hFFFFFFF0, 5'd7})
            $display("FAIL midrst_call: got v=%b fmt=%0d j=%b s=%b imm=%h rd=%0d expected v=1 fmt=2 j=1 s=1 imm=fffffff0 rd=7",
                     bus.out_valid, bus.out_format, bus.out_is_jump, bus.out_is_stack, bus.out_imm, bus.out_rd);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 1 || dut_bundle() !== exp_q[0])
            $display("FAIL midrst_call_model: got %h expected %h", dut_bundle(), exp_q.size() > 0 ? exp_q[0] : '0);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        logic acc;
        for (int i = 0; i < 400; i++) begin
            n_checks++;
            if (bus.out_valid !== (exp_q.size() > 0) || bus.in_ready !== (exp_q.size() < 2) ||
                (exp_q.size() > 0 && dut_bundle() !== exp_q[0]))
                $display("FAIL random_%0d: got v=%b rdy=%b %h expected depth=%0d %h",
                         i, bus.out_valid, bus.in_ready, dut_bundle(), exp_q.size(),
                         exp_q.size() > 0 ? exp_q[0] : '0);
            else n_pass++;
            tick($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0, acc);
        end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_add2();
        test_bgt();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port flush, input, 1, synchronous discard of all held instructions.
REQ-004 SHALL have port in_valid, input, 1, instruction word offered.
REQ-005 SHALL have port in_ready, output, 1, decoder accepts word this cycle.
REQ-006 SHALL have port in_instr, input, 32, raw instruction word.
REQ-007 SHALL have port out_valid, output, 1, decoded bundle valid.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts bundle.
REQ-009 SHALL have port out_opcode, output, 5, instructions enum value.
REQ-010 SHALL have port out_format, output, 2, formats enum value (T, D, I).
REQ-011 SHALL have ports out_rd, out_rs1, out_rs2, output, 5 each, register indices.
REQ-012 SHALL have port out_imm, output, 32, sign-extended immediate.
REQ-013 SHALL have port out_use_imm, output, 1, second ALU operand is out_imm.
REQ-014 SHALL have port out_alu_op, output, 3, operations enum value.
REQ-015 SHALL have port out_cond, output, 3, conditions enum value.
REQ-016 SHALL have ports out_is_branch, out_is_load, out_is_store, out_is_jump, out_is_stack, output, 1 each, class flags.

Function
REQ-017 SHALL split fields: opcode=[31:27], rd=[26:22], rs1=[21:17], rs2=[16:12].
REQ-018 SHALL set format T for opcodes ADD,SUB,MUL,DIV,AND,OR,LS,RS (even, 0-14), BEQ..BGE, SW, SB; imm=sext([11:0]); use_imm=0.
REQ-019 SHALL set format D for ADD2..RS2 (odd, 1-15), LW, LB, JR, PUSH; imm=sext([16:1]); use_imm=[0]; rs2=0.
REQ-020 SHALL set format I for J, CALL, RET, POP; imm=sext([21:0]); rs1=rs2=0; use_imm=1.
REQ-021 SHALL set alu_op=opcode[3:1] for opcodes 0-15; opADD for loads, stores, PUSH, POP.
REQ-022 SHALL set cond=opcode-16 for BEQ..BGE (EQ..GE), else EQ.
REQ-023 SHALL set flags: branch=BEQ..BGE; load=LW,LB; store=SW,SB; jump=J,JR,CALL,RET; stack=CALL,RET,PUSH,POP.
REQ-024 SHALL register all decoded outputs: accepted word appears on outputs the next cycle (latency 1).
REQ-025 SHALL implement a 2-entry skid buffer (output register plus one skid register).
REQ-026 SHALL drive in_ready from a register: 1 when skid register empty, 0 when full.
REQ-027 SHALL transfer in on in_valid&in_ready and out on out_valid&out_ready.
REQ-028 SHALL, when output empty or transferring, load output register from skid (if full) else from input.
REQ-029 SHALL, when input accepted while output held (out_valid&!out_ready), store decode in skid and drop in_ready next cycle.
REQ-030 SHALL preserve strict order; no word dropped or duplicated.
REQ-031 SHALL hold all out_* stable while out_valid&!out_ready.
REQ-032 SHALL on flush clear out_valid and skid, set in_ready=1, and ignore in_valid that cycle; flush overrides simultaneous transfers.
REQ-033 SHALL decode opcodes combinationally from in_instr before registering; skid stores decoded bundle.

Reset
REQ-034 SHALL on rst asynchronously clear out_valid, skid-full, and all out_* to 0, and set in_ready=1 from the first post-reset edge.
REQ-035 SHALL discard in-flight words when rst asserts mid-operation; no output after deassertion until new input.

Verification
REQ-036 SHALL test ADD2 rd=3 rs1=4 [16:1]=0xFFFF [0]=1 -> next cycle format=D, alu_op=opADD, imm=0xFFFFFFFF, use_imm=1.
REQ-037 SHALL test BGT rs1=1 rs2=2 [11:0]=0x010 -> format=T, cond=GT, is_branch=1, imm=0x00000010.
REQ-038 SHALL test out_ready=0 for 3 cycles with 3 words offered -> in_ready low after 2 accepted; outputs stable; order A,B,C after release.
REQ-039 SHALL test back-to-back stream with out_ready=1 -> one bundle per cycle, in_ready constant 1.
REQ-040 SHALL test flush with both entries full plus in_valid -> out_valid=0, in_ready=1 next cycle, no later output of flushed words.
REQ-041 SHALL test rst asserted mid-stream between edges -> outputs zero immediately, CALL afterwards decodes format=I, is_jump=is_stack=1.
